// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter: FSM state encoding,
// requester (owner) encoding and default bus widths / latency.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_MEM_LAT = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data requesters.
// When both are pending, the requester that was not the last owner wins.
// Fixed DM-over-IF priority falls out of this rule when last_owner is
// held at OWN_IF, so one selection circuit serves both arbitration modes.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   IF_REQ,
   input  logic   DM_REQ,
   input  owner_t last_owner,
   output logic   grant_valid,
   output owner_t grant_owner
);

   // pick the winner among the pending requesters
   always_comb begin
      grant_valid = IF_REQ | DM_REQ;
      grant_owner = OWN_IF;
      if (DM_REQ && !IF_REQ) begin
         grant_owner = OWN_DM;
      end else if (DM_REQ && IF_REQ) begin
         grant_owner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
      end
   end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch (IF) and
// load/store (DM) requesters. Serializes accesses, applies a fixed
// memory latency, returns registered read data and a one-cycle ACK.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration
// (last-owner register); otherwise DM has fixed priority over IF.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no access in flight; grant a pending request
// BUSY    | memory enabled with latched request, counting down latency
// DONE    | owner's ACK high for one cycle, memory idle, REQ ignored
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic              CLK,
   input  logic              RST_F,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   output logic [DATA_W-1:0] IF_RDATA,
   output logic              IF_ACK,
   input  logic              DM_REQ,
   input  logic              DM_WE,
   input  logic [ADDR_W-1:0] DM_ADDR,
   input  logic [DATA_W-1:0] DM_WDATA,
   output logic [DATA_W-1:0] DM_RDATA,
   output logic              DM_ACK,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              BUSY
);

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t     state;
   logic [3:0] count;
   owner_t     owner;
   owner_t     last_owner;
   logic       grant_valid;
   owner_t     grant_owner;

`ifndef MEM_ARB_RR_EN
   // fixed priority: pretend IF always owned last so DM wins ties
   assign last_owner = OWN_IF;
`endif

   mem_arb_pick u_pick (
      .IF_REQ      (IF_REQ),
      .DM_REQ      (DM_REQ),
      .last_owner  (last_owner),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // arbitration FSM; memory-side values double as the latched request
   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F) begin
         state     <= ST_IDLE;
         count     <= 4'd0;
         owner     <= OWN_IF;
`ifdef MEM_ARB_RR_EN
         last_owner <= OWN_IF;
`endif
         IF_RDATA  <= '0;
         IF_ACK    <= 1'b0;
         DM_RDATA  <= '0;
         DM_ACK    <= 1'b0;
         MEM_EN    <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         BUSY      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  state  <= ST_BUSY;
                  count  <= LAT_M1;
                  owner  <= grant_owner;
`ifdef MEM_ARB_RR_EN
                  last_owner <= grant_owner;
`endif
                  MEM_EN <= 1'b1;
                  BUSY   <= 1'b1;
                  if (grant_owner == OWN_DM) begin
                     MEM_WE    <= DM_WE;
                     MEM_ADDR  <= DM_ADDR;
                     MEM_WDATA <= DM_WDATA;
                  end else begin
                     MEM_WE    <= 1'b0;
                     MEM_ADDR  <= IF_ADDR;
                     MEM_WDATA <= '0;
                  end
               end
            end
            ST_BUSY: begin
               if (count == 4'd0) begin
                  state     <= ST_DONE;
                  MEM_EN    <= 1'b0;
                  MEM_WE    <= 1'b0;
                  MEM_ADDR  <= '0;
                  MEM_WDATA <= '0;
                  if (owner == OWN_IF) begin
                     IF_ACK   <= 1'b1;
                     IF_RDATA <= MEM_RDATA;
                  end else begin
                     DM_ACK <= 1'b1;
                     if (!MEM_WE) begin
                        DM_RDATA <= MEM_RDATA;
                     end
                  end
               end else begin
                  count <= count - 4'd1;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               IF_ACK <= 1'b0;
               DM_ACK <= 1'b0;
               BUSY   <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
